// File: rtl/branch_train_queue_pkg.sv
// Shared types and sizing for the branch training queue.
// Also carries the global address/depth defines used across the slice.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef TRAIN_QUEUE_DEPTH
`define TRAIN_QUEUE_DEPTH 8
`endif

package branch_train_queue_pkg;

  localparam int ADDR_W   = `ADDR_WIDTH;
  localparam int TQ_DEPTH = `TRAIN_QUEUE_DEPTH;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              taken;
  } train_rec_t;

  localparam int REC_W = $bits(train_rec_t);

  function automatic logic [31:0] sat_inc32(
    input logic [31:0] v
  );
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/train_fifo.sv
// Circular record buffer with wrapping pointers and occupancy count.
// A push while full is taken only when a pop frees the head slot.
module train_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          valid_o,
  output logic [AW:0]   count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full;
  logic          do_wr;
  logic          do_rd;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign do_rd = pop_i & (cnt_q != '0);
  assign do_wr = push_i & (~full | do_rd);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_wr) begin
      wr_d = wr_q + AW'(1);
    end
    if (do_rd) begin
      rd_d = rd_q + AW'(1);
    end
    unique case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && do_wr) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  // Empty reads as zero so stale storage never leaks after reset.
  assign valid_o = (cnt_q != '0);
  assign rdata_o = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/branch_train_queue.sv
// Buffers committed conditional branches for predictor training,
// and keeps saturating branch, mispredict and drop statistics.
module branch_train_queue
  import branch_train_queue_pkg::*;
#(
  parameter int DEPTH = TQ_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              commit_valid,
  input  logic              commit_is_branch,
  input  logic [ADDR_W-1:0] commit_pc,
  input  logic              commit_taken,
  input  logic              commit_pred_taken,
  output logic              train_enable,
  output logic              train_jump,
  output logic [ADDR_W-1:0] train_pc,
  input  logic              train_ready,
  output logic              queue_full,
  output logic [31:0]       branch_count,
  output logic [31:0]       mispredict_count,
  output logic [15:0]       drop_count
);

  logic        push_c;
  logic        pop_c;
  logic        drop_c;
  logic        misp_c;
  logic [AW:0] occ;
  train_rec_t  wrec;
  train_rec_t  head;
  logic [REC_W-1:0] head_raw;

  logic [31:0] br_q, br_d;
  logic [31:0] mp_q, mp_d;
  logic [15:0] dr_q, dr_d;

  assign push_c = rdy & commit_valid & commit_is_branch;
  assign pop_c  = rdy & train_enable & train_ready;
  assign misp_c = push_c & (commit_taken != commit_pred_taken);
  assign drop_c = push_c & queue_full & ~pop_c;

  assign wrec = '{pc: commit_pc, taken: commit_taken};

  train_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .wdata_i (wrec),
    .rdata_o (head_raw),
    .valid_o (train_enable),
    .count_o (occ)
  );

  assign head       = train_rec_t'(head_raw);
  assign train_pc   = head.pc;
  assign train_jump = head.taken;
  assign queue_full = (occ == (AW+1)'(DEPTH));

  always_comb begin
    br_d = br_q;
    mp_d = mp_q;
    dr_d = dr_q;
    if (push_c) begin
      br_d = sat_inc32(br_q);
    end
    if (misp_c) begin
      mp_d = sat_inc32(mp_q);
    end
    if (drop_c) begin
      dr_d = sat_inc16(dr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      br_q <= '0;
      mp_q <= '0;
      dr_q <= '0;
    end else begin
      br_q <= br_d;
      mp_q <= mp_d;
      dr_q <= dr_d;
    end
  end

  assign branch_count     = br_q;
  assign mispredict_count = mp_q;
  assign drop_count       = dr_q;

endmodule

// File: tb/tb_branch_train_queue.sv
// Scoreboard bench: stimulus feeds a queue-based model,
// a negedge monitor compares the DUT against it.
module tb_branch_train_queue;
  import branch_train_queue_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b0;
  logic        commit_valid = 1'b0;
  logic        commit_is_branch = 1'b0;
  logic [31:0] commit_pc = '0;
  logic        commit_taken = 1'b0;
  logic        commit_pred_taken = 1'b0;
  logic        train_ready = 1'b0;
  logic        train_enable;
  logic        train_jump;
  logic [31:0] train_pc;
  logic        queue_full;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
  logic [15:0] drop_count;

  branch_train_queue #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .commit_valid      (commit_valid),
    .commit_is_branch  (commit_is_branch),
    .commit_pc         (commit_pc),
    .commit_taken      (commit_taken),
    .commit_pred_taken (commit_pred_taken),
    .train_enable      (train_enable),
    .train_jump        (train_jump),
    .train_pc          (train_pc),
    .train_ready       (train_ready),
    .queue_full        (queue_full),
    .branch_count      (branch_count),
    .mispredict_count  (mispredict_count),
    .drop_count        (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        tk;
  } rec_t;

  rec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   chk_en = 0;
  bit   clr_pend = 0;
  int   cur_occ = 0, nxt_occ = 0;
  int unsigned cur_bc = 0, nxt_bc = 0;
  int unsigned cur_mp = 0, nxt_mp = 0;
  int unsigned cur_dr = 0, nxt_dr = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model predicts the effect of the next edge.
  task automatic cyc(input bit r_n, input bit rd,
                     input bit cv, input bit cb,
                     input logic [31:0] pc, input bit tk,
                     input bit pt, input bit tr);
    bit pop, push, acc;
    @(posedge clk);
    #1;
    cur_occ = nxt_occ;
    cur_bc  = nxt_bc;
    cur_mp  = nxt_mp;
    cur_dr  = nxt_dr;
    if (clr_pend) begin
      exp_q.delete();
      clr_pend = 0;
    end
    rst = r_n;
    rdy = rd;
    commit_valid = cv;
    commit_is_branch = cb;
    commit_pc = pc;
    commit_taken = tk;
    commit_pred_taken = pt;
    train_ready = tr;
    if (!r_n) begin
      nxt_occ = 0;
      nxt_bc = 0;
      nxt_mp = 0;
      nxt_dr = 0;
      clr_pend = 1;
    end else if (rd) begin
      pop  = tr && (cur_occ > 0);
      push = cv && cb;
      acc  = push && (cur_occ < DEPTH || pop);
      if (push) begin
        if (cur_bc != 32'hFFFF_FFFF) nxt_bc = cur_bc + 1;
        if (tk != pt && cur_mp != 32'hFFFF_FFFF) nxt_mp = cur_mp + 1;
        if (acc) exp_q.push_back('{pc, tk});
        else if (cur_dr != 16'hFFFF) nxt_dr = cur_dr + 1;
      end
      nxt_occ = cur_occ + int'(acc) - int'(pop);
    end
  endtask

  task automatic idle(input bit tr, input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 0, 0, 0, 0, 0, tr);
  endtask

  task automatic br(input logic [31:0] pc, input bit tk,
                    input bit pt, input bit tr);
    cyc(1, 1, 1, 1, pc, tk, pt, tr);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("train_enable", train_enable, cur_occ > 0);
      chk("queue_full", queue_full, cur_occ == DEPTH);
      chk("branch_count", branch_count, cur_bc);
      chk("mispredict_count", mispredict_count, cur_mp);
      chk("drop_count", drop_count, cur_dr);
      if (train_enable && exp_q.size() > 0) begin
        chk("train_pc", train_pc, exp_q[0].pc);
        chk("train_jump", train_jump, exp_q[0].tk);
        if (rdy && train_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;

    // FIFO order with delayed consumption
    br(32'h100, 1, 1, 0);
    br(32'h104, 0, 0, 0);
    br(32'h108, 1, 1, 0);
    idle(1, 5);

    // overflow, then full push+pop, then drain
    for (int i = 0; i < DEPTH; i++)
      br(32'h200 + 4 * i, i % 2, 0, 0);
    br(32'h300, 1, 1, 0);
    idle(0, 2);
    br(32'h400, 0, 1, 1);
    idle(0, 1);
    idle(1, DEPTH + 2);

    // counters with interleaved non-branch commits
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    br(32'h500, 1, 0, 0);
    cyc(1, 1, 1, 0, 32'h504, 1, 0, 0);
    br(32'h508, 0, 0, 0);
    cyc(1, 1, 1, 0, 32'h50c, 0, 1, 0);
    br(32'h510, 0, 1, 0);
    cyc(1, 1, 1, 0, 32'h514, 1, 1, 0);
    br(32'h518, 1, 1, 0);
    idle(0, 1);

    // global stall blocks push, pop and counters
    cyc(1, 0, 1, 1, 32'h600, 1, 0, 1);
    cyc(1, 0, 1, 1, 32'h604, 0, 1, 1);
    idle(0, 1);

    // reset with queued records and a pending push
    br(32'h700, 1, 0, 0);
    cyc(0, 1, 1, 1, 32'h704, 1, 0, 1);
    br(32'h708, 1, 0, 0);
    @(negedge clk);
    chk("rst_train_pc", train_pc, 0);
    chk("rst_train_jump", train_jump, 0);
    idle(1, 3);

    // randomized traffic, low then high drain rate
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        cyc(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 7),
            $urandom() & 32'hFFFF_FFFC,
            $urandom_range(0, 1),
            $urandom_range(0, 1),
            ($urandom_range(0, 9) < (ph == 0 ? 3 : 8)));
      end
    end
    idle(1, DEPTH + 2);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
